// File: rtl/dmem_resp_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets, STATUS bit
// positions and the address-region decode helper.
package dmem_resp_pkg;

  // Byte offsets of the MMIO registers within the 16-byte page
  localparam logic [3:0] CON_OFS  = 4'h0;
  localparam logic [3:0] STAT_OFS = 4'h4;
  localparam logic [3:0] CYC_OFS  = 4'h8;
  localparam logic [3:0] HOST_OFS = 4'hC;

  localparam int unsigned ST_OVF  = 9;
  localparam int unsigned ST_FULL = 8;

  localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;

  typedef enum logic [1:0] {
    RegionRam,
    RegionMmio,
    RegionNone
  } region_e;

  // RAM takes priority; the MMIO page is matched on the 16-byte aligned address
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes,
                                            input logic [31:0] mmio_base);
    region_e region;
    if (addr < ram_bytes) begin
      region = RegionRam;
    end else if ((addr & 32'hFFFF_FFF0) == (mmio_base & 32'hFFFF_FFF0)) begin
      region = RegionMmio;
    end else begin
      region = RegionNone;
    end
    return region;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO for console bytes: registered output (no fall-through), push accepted
// when full only if a pop happens in the same cycle.
module byte_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign valid     = (r_count != '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign dout      = r_mem[r_rptr];
  assign w_do_pop  = pop & valid;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-masked word RAM plus an MMIO page with console FIFO,
// status, free-running cycle counter and sticky TOHOST halt register.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  input  logic        dmem_write,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        halt,
  output logic [31:0] tohost,
  output logic        bus_err
);

  localparam int unsigned   AW        = $clog2(DEPTH);
  localparam int unsigned   CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0]   RAM_BYTES = 32'(DEPTH * 4);

  logic [31:0]      r_mem [DEPTH];
  logic [31:0]      r_cycle;
  logic [31:0]      r_tohost;
  logic             r_halt;
  logic             r_ovf;
  logic             r_bus_err;

  region_e          w_region;
  logic [AW-1:0]    w_word;
  logic [1:0]       w_ofs;
  logic             w_mmio;
  logic             w_wr_ram;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_set;
  logic             w_ovf_clr;
  logic             w_host_wr;
  logic             w_full;
  logic [CNT_W-1:0] w_count;
  logic [31:0]      w_status;

  assign w_region = decode_region(dmem_addr, RAM_BYTES, MMIO_BASE);
  assign w_word   = dmem_addr[AW+1:2];
  assign w_ofs    = dmem_addr[3:2];
  assign w_mmio   = (w_region == RegionMmio);

  assign w_wr_ram  = dmem_write & (w_region == RegionRam);
  assign w_push    = dmem_write & w_mmio & (w_ofs == CON_OFS[3:2]) & dmem_wmask[0];
  assign w_pop     = con_valid & con_ready;
  // A push into a full FIFO survives only when a pop frees a slot on the same edge
  assign w_ovf_set = w_push & w_full & ~w_pop;
  assign w_ovf_clr = dmem_write & w_mmio & (w_ofs == STAT_OFS[3:2]) & dmem_wmask[1]
                   & dmem_wdata[ST_OVF];
  assign w_host_wr = dmem_write & w_mmio & (w_ofs == HOST_OFS[3:2]) & (|dmem_wmask)
                   & ~r_halt;

  assign w_status = {22'b0, r_ovf, w_full, 8'(w_count)};

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_con_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (dmem_wdata[7:0]),
    .pop   (w_pop),
    .dout  (con_data),
    .valid (con_valid),
    .full  (w_full),
    .count (w_count)
  );

  always_comb begin
    dmem_rdata = UNMAPPED_RDATA;
    case (w_region)
      RegionRam: dmem_rdata = r_mem[w_word];
      RegionMmio: begin
        case (w_ofs)
          CYC_OFS[3:2]:  dmem_rdata = r_cycle;
          STAT_OFS[3:2]: dmem_rdata = w_status;
          HOST_OFS[3:2]: dmem_rdata = r_tohost;
          default:       dmem_rdata = 32'h0;
        endcase
      end
      default: dmem_rdata = UNMAPPED_RDATA;
    endcase
  end

  // RAM is deliberately not reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_wr_ram && dmem_wmask[i]) begin
        r_mem[w_word][8*i +: 8] <= dmem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle   <= '0;
      r_tohost  <= '0;
      r_halt    <= 1'b0;
      r_ovf     <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_host_wr) begin
        r_halt   <= 1'b1;
        r_tohost <= dmem_wdata;
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
      if (w_region == RegionNone) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  assign halt    = r_halt;
  assign tohost  = r_tohost;
  assign bus_err = r_bus_err;

endmodule
